// File: rtl/prog_counter_gen2.sv
// Programmable up/down counter with wrap, one-shot, reload and ping-pong modes.
// Optional prescaler when PRESCALE_EN is defined; otherwise every enabled cycle steps.
module prog_counter_gen2 #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter int unsigned      PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [WIDTH-1:0]      cmp_val,
  input  logic [PRESCALE_W-1:0] presc,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  cmp_hit,
  output logic                  running,
  output logic                  done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_running;
  logic             r_done;
  logic             r_tc;
  logic             r_cmp_hit;
  logic             r_pp_dir;

  logic             w_tick;
  logic             w_step;
  logic             w_dir_eff;
  logic             w_term;
  logic [WIDTH-1:0] w_next;

`ifdef PRESCALE_EN
  logic [PRESCALE_W-1:0] r_presc;

  assign w_tick = (r_presc == presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (load) begin
      r_presc <= '0;
    end else if (r_running && en) begin
      r_presc <= w_tick ? '0 : r_presc + PRESCALE_W'(1);
    end
  end
`else
  logic w_unused_presc;
  assign w_unused_presc = ^presc;
  assign w_tick         = 1'b1;
`endif

  assign w_step    = r_running & en & w_tick & ~load;
  assign w_dir_eff = (mode == 2'b11) ? r_pp_dir : dir;
  assign w_term    = w_dir_eff ? (r_count == limit) : (r_count == '0);

  always_comb begin
    w_next = r_count;
    if (!w_term) begin
      w_next = w_dir_eff ? r_count + ONE : r_count - ONE;
    end else begin
      unique case (mode)
        2'b00:   w_next = w_dir_eff ? '0 : limit;
        2'b01:   w_next = r_count;
        2'b10:   w_next = r_reload;
        default: begin
          // Bounce off the end; a zero limit leaves nowhere to go.
          if (limit == '0) w_next = '0;
          else             w_next = w_dir_eff ? limit - ONE : ONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= RESET_VAL;
      r_reload  <= RESET_VAL;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_tc      <= 1'b0;
      r_cmp_hit <= 1'b0;
      r_pp_dir  <= 1'b1;
    end else begin
      r_tc      <= 1'b0;
      r_cmp_hit <= 1'b0;
      if (load) begin
        r_count  <= load_val;
        r_reload <= load_val;
        r_done   <= 1'b0;
        r_pp_dir <= dir;
        if (stop)       r_running <= 1'b0;
        else if (start) r_running <= 1'b1;
      end else begin
        if (stop) begin
          r_running <= 1'b0;
        end else if (start) begin
          r_running <= 1'b1;
          r_done    <= 1'b0;
          r_pp_dir  <= dir;
        end
        if (w_step) begin
          r_count   <= w_next;
          r_tc      <= w_term;
          r_cmp_hit <= (w_next == cmp_val);
          if (w_term && mode == 2'b01) begin
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end
          if (w_term && mode == 2'b11) r_pp_dir <= ~r_pp_dir;
        end
      end
    end
  end

  assign count   = r_count;
  assign tc      = r_tc;
  assign cmp_hit = r_cmp_hit;
  assign running = r_running;
  assign done    = r_done;

endmodule
